// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control path: opcode width, opcode constants,
// ALUOp codes and the FSM state encoding, visible to the datapath as well.
package multicycle_ctrl_pkg;

  localparam int OPCODE_WIDTH_DEF = 6;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Encodings 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } mc_state_e;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: state-decoded datapath controls, illegal-opcode pulse, retired-instruction counter.
// Controls settle combinationally from state; FETCH/MEMRD/MEMWR stall until mc_i_mem_ready.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    mc_clk,
  input  logic                    mc_rst,
  input  logic                    mc_i_en,
  input  logic [OPCODE_WIDTH-1:0] mc_i_opcode,
  input  logic                    mc_i_mem_ready,
  output logic                    mc_o_ce,
  output logic                    mc_o_IRWrite,
  output logic                    mc_o_PCWrite,
  output logic                    mc_o_Branch,
  output logic                    mc_o_Jump,
  output logic                    mc_o_RegDst,
  output logic                    mc_o_RegWrite,
  output logic                    mc_o_ALUSrc,
  output logic                    mc_o_MemRead,
  output logic                    mc_o_MemWrite,
  output logic                    mc_o_MemtoReg,
  output logic [1:0]              mc_o_ALUOp,
  output logic [3:0]              mc_o_state,
  output logic                    mc_o_illegal,
  output logic [CNT_WIDTH-1:0]    mc_o_instr_cnt
);

  localparam logic [OPCODE_WIDTH-1:0] OPC_LW    = OPCODE_WIDTH'(OP_LW);
  localparam logic [OPCODE_WIDTH-1:0] OPC_SW    = OPCODE_WIDTH'(OP_SW);
  localparam logic [OPCODE_WIDTH-1:0] OPC_RTYPE = OPCODE_WIDTH'(OP_RTYPE);
  localparam logic [OPCODE_WIDTH-1:0] OPC_BEQ   = OPCODE_WIDTH'(OP_BEQ);
  localparam logic [OPCODE_WIDTH-1:0] OPC_ADDI  = OPCODE_WIDTH'(OP_ADDI);
  localparam logic [OPCODE_WIDTH-1:0] OPC_J     = OPCODE_WIDTH'(OP_J);

  mc_state_e state, state_nxt;
  logic      illegal_nxt;
  logic      retire;
  logic      en_run;

  // Reset forces the FETCH strobes to their idle (en=0) values.
  assign en_run     = mc_i_en & ~mc_rst;
  assign mc_o_state = state;

  always_ff @(posedge mc_clk) begin
    if (mc_rst) begin
      state          <= S_FETCH;
      mc_o_illegal   <= 1'b0;
      mc_o_instr_cnt <= '0;
    end else begin
      state        <= state_nxt;
      mc_o_illegal <= illegal_nxt;
      if (retire) begin
        mc_o_instr_cnt <= mc_o_instr_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    illegal_nxt   = 1'b0;
    retire        = 1'b0;
    mc_o_ce       = 1'b1;
    mc_o_IRWrite  = 1'b0;
    mc_o_PCWrite  = 1'b0;
    mc_o_Branch   = 1'b0;
    mc_o_Jump     = 1'b0;
    mc_o_RegDst   = 1'b0;
    mc_o_RegWrite = 1'b0;
    mc_o_ALUSrc   = 1'b0;
    mc_o_MemRead  = 1'b0;
    mc_o_MemWrite = 1'b0;
    mc_o_MemtoReg = 1'b0;
    mc_o_ALUOp    = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        mc_o_ce      = en_run;
        mc_o_MemRead = en_run;
        mc_o_IRWrite = en_run & mc_i_mem_ready;
        mc_o_PCWrite = en_run & mc_i_mem_ready;
        if (en_run && mc_i_mem_ready) begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (mc_i_opcode)
          OPC_LW, OPC_SW: state_nxt = S_MEMADR;
          OPC_RTYPE:      state_nxt = S_EXEC;
          OPC_BEQ:        state_nxt = S_BRANCH;
          OPC_ADDI:       state_nxt = S_ADDIEX;
          OPC_J:          state_nxt = S_JUMP;
          default: begin
            state_nxt   = S_FETCH;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        mc_o_ALUSrc = 1'b1;
        state_nxt   = (mc_i_opcode == OPC_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mc_o_MemRead = 1'b1;
        if (mc_i_mem_ready) begin
          state_nxt = S_MEMWB;
        end
      end
      S_MEMWB: begin
        mc_o_MemtoReg = 1'b1;
        mc_o_RegWrite = 1'b1;
        state_nxt     = S_FETCH;
        retire        = 1'b1;
      end
      S_MEMWR: begin
        mc_o_MemWrite = 1'b1;
        if (mc_i_mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_EXEC: begin
        mc_o_ALUOp = ALUOP_FUNCT;
        state_nxt  = S_ALUWB;
      end
      S_ALUWB: begin
        mc_o_RegDst   = 1'b1;
        mc_o_RegWrite = 1'b1;
        state_nxt     = S_FETCH;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        mc_o_ALUOp  = ALUOP_SUB;
        mc_o_Branch = 1'b1;
        state_nxt   = S_FETCH;
        retire      = 1'b1;
      end
      S_ADDIEX: begin
        mc_o_ALUSrc = 1'b1;
        state_nxt   = S_ADDIWB;
      end
      S_ADDIWB: begin
        mc_o_RegWrite = 1'b1;
        state_nxt     = S_FETCH;
        retire        = 1'b1;
      end
      S_JUMP: begin
        mc_o_Jump    = 1'b1;
        mc_o_PCWrite = 1'b1;
        state_nxt    = S_FETCH;
        retire       = 1'b1;
      end
      default: begin
        mc_o_ce   = 1'b0;
        state_nxt = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed and randomized bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic ce, irw, pcw, br, jmp, regdst, regw, alusrc, memrd, memwr, memtoreg;
    logic [1:0] aluop;
  } ctl_t;

  logic       mc_clk;
  logic       mc_rst;
  logic       mc_i_en;
  logic [5:0] mc_i_opcode;
  logic       mc_i_mem_ready;
  logic       mc_o_ce, mc_o_IRWrite, mc_o_PCWrite, mc_o_Branch, mc_o_Jump;
  logic       mc_o_RegDst, mc_o_RegWrite, mc_o_ALUSrc, mc_o_MemRead, mc_o_MemWrite, mc_o_MemtoReg;
  logic [1:0] mc_o_ALUOp;
  logic [3:0] mc_o_state;
  logic       mc_o_illegal;
  logic [3:0] mc_o_instr_cnt;

  ctl_t       ctl_obs;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] cnt_exp = '0;
  bit         ill_pend = 0;

  multicycle_ctrl #(.OPCODE_WIDTH(6), .CNT_WIDTH(4)) dut (
    .mc_clk(mc_clk), .mc_rst(mc_rst), .mc_i_en(mc_i_en), .mc_i_opcode(mc_i_opcode),
    .mc_i_mem_ready(mc_i_mem_ready), .mc_o_ce(mc_o_ce), .mc_o_IRWrite(mc_o_IRWrite),
    .mc_o_PCWrite(mc_o_PCWrite), .mc_o_Branch(mc_o_Branch), .mc_o_Jump(mc_o_Jump),
    .mc_o_RegDst(mc_o_RegDst), .mc_o_RegWrite(mc_o_RegWrite), .mc_o_ALUSrc(mc_o_ALUSrc),
    .mc_o_MemRead(mc_o_MemRead), .mc_o_MemWrite(mc_o_MemWrite), .mc_o_MemtoReg(mc_o_MemtoReg),
    .mc_o_ALUOp(mc_o_ALUOp), .mc_o_state(mc_o_state), .mc_o_illegal(mc_o_illegal),
    .mc_o_instr_cnt(mc_o_instr_cnt)
  );

  assign ctl_obs = {mc_o_ce, mc_o_IRWrite, mc_o_PCWrite, mc_o_Branch, mc_o_Jump, mc_o_RegDst,
                    mc_o_RegWrite, mc_o_ALUSrc, mc_o_MemRead, mc_o_MemWrite, mc_o_MemtoReg, mc_o_ALUOp};

  initial mc_clk = 1'b0;
  always #5 mc_clk = ~mc_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Control table per state; FETCH strobes depend on run enable and memory ready.
  function automatic ctl_t ctl_exp(input int s, input logic en, input logic rdy);
    ctl_t c;
    c = '0;
    c.ce = 1'b1;
    case (s)
      0:  begin c.ce = en; c.memrd = en; c.irw = en & rdy; c.pcw = en & rdy; end
      1:  c.aluop = 2'b00;
      2:  c.alusrc = 1'b1;
      3:  c.memrd = 1'b1;
      4:  begin c.regw = 1'b1; c.memtoreg = 1'b1; end
      5:  c.memwr = 1'b1;
      6:  c.aluop = 2'b10;
      7:  begin c.regdst = 1'b1; c.regw = 1'b1; end
      8:  begin c.aluop = 2'b01; c.br = 1'b1; end
      9:  c.alusrc = 1'b1;
      10: c.regw = 1'b1;
      11: begin c.jmp = 1'b1; c.pcw = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the expected state and outputs, then take the edge.
  task automatic cycle(input int s, input logic en, input logic rdy, input logic [5:0] op,
                       input logic rst);
    ctl_t ce;
    @(negedge mc_clk);
    mc_rst = rst; mc_i_en = en; mc_i_mem_ready = rdy; mc_i_opcode = op;
    #1;
    ce = ctl_exp(s, en & ~rst, rdy);
    chk($sformatf("state(s%0d)", s), 16'(mc_o_state), 16'(s));
    chk($sformatf("ctl(s%0d)", s), 16'(ctl_obs), 16'(ce));
    chk($sformatf("illegal(s%0d)", s), 16'(mc_o_illegal), 16'(ill_pend));
    chk($sformatf("cnt(s%0d)", s), 16'(mc_o_instr_cnt), 16'(cnt_exp));
    ill_pend = 0;
    @(posedge mc_clk);
    if (rst) cnt_exp = '0;
  endtask

  // Runs one instruction through its state path; memory-wait states repeat per ready=0 cycle.
  task automatic exec_instr(input logic [5:0] op, input int wf, input int wm, input bit rnd);
    int p[$];
    bit legal;
    legal = 1;
    case (op)
      LW:   p = '{0, 1, 2, 3, 4};
      SW:   p = '{0, 1, 2, 5};
      RT:   p = '{0, 1, 6, 7};
      BEQ:  p = '{0, 1, 8};
      ADDI: p = '{0, 1, 9, 10};
      J:    p = '{0, 1, 11};
      default: begin p = '{0, 1}; legal = 0; end
    endcase
    foreach (p[i]) begin
      int s;
      int w;
      logic [5:0] o;
      logic e;
      s = p[i];
      w = (s == 0) ? wf : wm;
      o = (s == 0) ? 6'($urandom) : op;
      e = (s == 0) ? 1'b1 : (rnd ? 1'($urandom) : 1'b1);
      if (rnd) w = $urandom_range(0, 2);
      if (s == 0 || s == 3 || s == 5) begin
        repeat (w) cycle(s, e, 1'b0, o, 1'b0);
        cycle(s, e, 1'b1, o, 1'b0);
      end else begin
        cycle(s, e, rnd ? 1'($urandom) : 1'b1, o, 1'b0);
      end
    end
    if (legal) cnt_exp++;
    else ill_pend = 1;
  endtask

  initial begin
    mc_rst = 1'b1; mc_i_en = 1'b1; mc_i_mem_ready = 1'b1; mc_i_opcode = LW;
    repeat (2) @(posedge mc_clk);
    cycle(0, 1'b1, 1'b1, LW, 1'b1);
    cycle(0, 1'b1, 1'b1, LW, 1'b1);

    // lw with no waits: 0,1,2,3,4 then back to FETCH
    exec_instr(LW, 0, 0, 0);
    #1 chk("lw_cnt", 16'(mc_o_instr_cnt), 16'd1);

    // sw with three ready=0 cycles in MEMWR
    exec_instr(SW, 0, 3, 0);
    #1 chk("sw_cnt", 16'(mc_o_instr_cnt), 16'd2);

    // Back-to-back R-type, beq, j
    exec_instr(RT, 0, 0, 0);
    exec_instr(BEQ, 0, 0, 0);
    exec_instr(J, 0, 0, 0);
    #1 chk("rbj_cnt", 16'(mc_o_instr_cnt), 16'd5);

    // Illegal opcode, then fetch waits on an addi; pulse seen on the first following cycle only
    exec_instr(BAD, 0, 0, 0);
    exec_instr(ADDI, 2, 0, 0);
    #1 chk("after_illegal_cnt", 16'(mc_o_instr_cnt), 16'd6);

    // Reset during a MEMRD wait, then park with en=0
    cycle(0, 1'b1, 1'b1, LW, 1'b0);
    cycle(1, 1'b1, 1'b1, LW, 1'b0);
    cycle(2, 1'b1, 1'b1, LW, 1'b0);
    cycle(3, 1'b1, 1'b0, LW, 1'b0);
    cycle(3, 1'b1, 1'b0, LW, 1'b1);
    #1 chk("midwait_rst_state", 16'(mc_o_state), 16'd0);
    chk("midwait_rst_cnt", 16'(mc_o_instr_cnt), 16'd0);
    repeat (3) cycle(0, 1'b0, 1'b1, LW, 1'b0);

    // Counter wrap at CNT_WIDTH=4
    for (int k = 0; k < 15; k++) exec_instr(ADDI, 0, 0, 0);
    #1 chk("cnt_all_ones", 16'(mc_o_instr_cnt), 16'hF);
    exec_instr(ADDI, 0, 0, 0);
    #1 chk("cnt_wrap", 16'(mc_o_instr_cnt), 16'd0);

    // Randomized mix with memory waits, idle cycles and en toggling mid-instruction
    for (int k = 0; k < 40; k++) begin
      logic [5:0] op;
      int pick;
      pick = $urandom_range(0, 7);
      case (pick)
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = ADDI;
        5: op = J;
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) cycle(0, 1'b0, 1'($urandom), 6'($urandom), 1'b0);
      exec_instr(op, $urandom_range(0, 2), 0, 1);
    end
    cycle(0, 1'b0, 1'b1, 6'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
